accelbrot_loop_array: RTL and testbench

Multi-ring front end for the Mandelbrot iteration engine. It spreads entering points across NLOOPS independent iteration rings, picking the least-occupied eligible ring for each point. It merges the rings' exit streams into one through a round-robin arbiter and keeps global and per-ring occupancy status. It sits between the point generator and NLOOPS ring instances, and adds load balancing, per-ring capacity limiting and a drain mode.

---
 rtl/accelbrot_pkg.sv | 25 ++
 rtl/accelbrot_rr_arbiter.sv | 42 ++++
 rtl/accelbrot_loop_array.sv | 167 ++++++++++++++++
 tb/tb_accelbrot_loop_array.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accelbrot_pkg.sv
// Shared definitions for the multi-ring Mandelbrot front end.
//   clog2_min1  : ring-index width helper, never returns 0
//   STS_WIDTH   : width of the wrapping status counters
//   exit_rec_t  : merged exit record for default-width builds
package accelbrot_pkg;

  localparam int STS_WIDTH  = 32;
  localparam int DEF_TWIDTH = 24;
  localparam int DEF_CWIDTH = 20;
  localparam int DEF_NLOOPS = 4;

  // A single ring still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_LWIDTH = clog2_min1(DEF_NLOOPS);

  typedef struct packed {
    logic [DEF_TWIDTH-1:0] tag;
    logic [DEF_CWIDTH-1:0] count;
    logic [DEF_LWIDTH-1:0] loop;
  } exit_rec_t;

endpackage

// File: rtl/accelbrot_rr_arbiter.sv
// Round-robin arbiter for the ring exit streams.
//   req       : per-ring request
//   advance   : downstream can take a result; grant only when set
//   grant     : one-hot grant (zero when no grant)
//   grant_idx : index of the granted ring
// The priority pointer moves to grant+1 after every grant.
module accelbrot_rr_arbiter
  import accelbrot_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0]  ptr;
  logic [2*N-1:0] dbl;

  // Doubling the request vector lets the search start at ptr and run N
  // positions without a wrap test; walking k downward leaves the closest
  // request to ptr as the final assignment.
  always_comb begin
    dbl       = {req, req};
    grant_idx = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (dbl[int'(ptr) + k]) grant_idx = IW'((int'(ptr) + k) % N);
    end
    grant = (advance && |req) ? (N'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance && |req)
      ptr <= (int'(grant_idx) == N-1) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/accelbrot_loop_array.sv
// Multi-ring front end: balances entering points over NLOOPS iteration
// rings (least-occupied eligible ring wins, lowest index on ties), merges
// the ring exits round-robin into one stream, and tracks occupancy.
//   clk/rst          : clock, synchronous active-high reset
//   ctl_drain        : stop accepting new points
//   sts_*            : busy flag, wrapping entered/exited/running counters,
//                      per-ring in-flight counts
//   enter_*          : point input (valid/ready)
//   loop_enter_*     : broadcast point data, one-hot valid, per-ring bp
//   loop_exit_*      : per-ring results, one-hot ready
//   exit_*           : merged result stream with source ring index
module accelbrot_loop_array
  import accelbrot_pkg::*;
#(
  parameter  int NLOOPS   = 4,
  parameter  int WWIDTH   = 34,
  parameter  int CWIDTH   = 20,
  parameter  int TWIDTH   = 24,
  parameter  int LOOP_CAP = 16,
  localparam int OWIDTH   = $clog2(LOOP_CAP+1),
  localparam int LWIDTH   = clog2_min1(NLOOPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ctl_drain,
  output logic                       sts_busy,
  output logic [STS_WIDTH-1:0]       sts_num_entered,
  output logic [STS_WIDTH-1:0]       sts_num_exited,
  output logic [STS_WIDTH-1:0]       sts_num_running,
  output logic [NLOOPS*OWIDTH-1:0]   sts_occupancy,
  input  logic [WWIDTH-1:0]          enter_a,
  input  logic [WWIDTH-1:0]          enter_b,
  input  logic [TWIDTH-1:0]          enter_tag,
  input  logic                       enter_valid,
  output logic                       enter_ready,
  output logic [NLOOPS*WWIDTH-1:0]   loop_enter_a,
  output logic [NLOOPS*WWIDTH-1:0]   loop_enter_b,
  output logic [NLOOPS*TWIDTH-1:0]   loop_enter_tag,
  output logic [NLOOPS-1:0]          loop_enter_valid,
  input  logic [NLOOPS-1:0]          loop_enter_bp,
  input  logic [NLOOPS*TWIDTH-1:0]   loop_exit_tag,
  input  logic [NLOOPS*CWIDTH-1:0]   loop_exit_count,
  input  logic [NLOOPS-1:0]          loop_exit_valid,
  output logic [NLOOPS-1:0]          loop_exit_ready,
  output logic [TWIDTH-1:0]          exit_tag,
  output logic [CWIDTH-1:0]          exit_count,
  output logic [LWIDTH-1:0]          exit_loop,
  output logic                       exit_valid,
  input  logic                       exit_ready
);

  // input register
  logic              in_valid;
  logic [WWIDTH-1:0] in_a, in_b;
  logic [TWIDTH-1:0] in_tag;

  logic [NLOOPS-1:0][OWIDTH-1:0] occ;
  logic [NLOOPS-1:0]             elig, inc, dec;
  logic [LWIDTH-1:0]             tgt;
  logic [OWIDTH-1:0]             best_occ;
  logic                          have_elig, dispatch_fire;
  logic                          enter_hs, exit_hs, advance;
  logic [NLOOPS-1:0]             grant;
  logic [LWIDTH-1:0]             grant_idx;

  // Least-occupancy selection; strict '<' keeps the lowest index on ties.
  always_comb begin
    elig      = '0;
    tgt       = '0;
    best_occ  = '0;
    have_elig = 1'b0;
    for (int i = 0; i < NLOOPS; i++) begin
      elig[i] = !loop_enter_bp[i] && (occ[i] < OWIDTH'(LOOP_CAP));
      if (elig[i] && (!have_elig || occ[i] < best_occ)) begin
        have_elig = 1'b1;
        best_occ  = occ[i];
        tgt       = LWIDTH'(i);
      end
    end
  end

  assign dispatch_fire    = in_valid && have_elig;
  assign loop_enter_valid = dispatch_fire ? (NLOOPS'(1) << tgt) : '0;
  assign loop_enter_a     = {NLOOPS{in_a}};
  assign loop_enter_b     = {NLOOPS{in_b}};
  assign loop_enter_tag   = {NLOOPS{in_tag}};

  // Gated by rst so every output reads 0 while reset is held.
  assign enter_ready = !rst && !ctl_drain && (!in_valid || dispatch_fire);
  assign enter_hs    = enter_valid && enter_ready;
  assign exit_hs     = exit_valid && exit_ready;
  assign advance     = !rst && (!exit_valid || exit_ready);

  assign inc = loop_enter_valid;
  assign dec = loop_exit_valid & loop_exit_ready;

  accelbrot_rr_arbiter #(.N(NLOOPS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (loop_exit_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign loop_exit_ready = grant;
  assign sts_occupancy   = occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid        <= 1'b0;
      in_a            <= '0;
      in_b            <= '0;
      in_tag          <= '0;
      exit_valid      <= 1'b0;
      exit_tag        <= '0;
      exit_count      <= '0;
      exit_loop       <= '0;
      occ             <= '0;
      sts_num_entered <= '0;
      sts_num_exited  <= '0;
      sts_num_running <= '0;
      sts_busy        <= 1'b0;
    end else begin
      if (enter_hs) begin
        in_valid <= 1'b1;
        in_a     <= enter_a;
        in_b     <= enter_b;
        in_tag   <= enter_tag;
      end else if (dispatch_fire) begin
        in_valid <= 1'b0;
      end

      if (|grant) begin
        exit_valid <= 1'b1;
        exit_tag   <= loop_exit_tag[int'(grant_idx)*TWIDTH +: TWIDTH];
        exit_count <= loop_exit_count[int'(grant_idx)*CWIDTH +: CWIDTH];
        exit_loop  <= grant_idx;
      end else if (exit_hs) begin
        exit_valid <= 1'b0;
      end

      for (int i = 0; i < NLOOPS; i++) begin
        if (inc[i] && !dec[i])      occ[i] <= occ[i] + 1'b1;
        else if (!inc[i] && dec[i]) occ[i] <= occ[i] - 1'b1;
      end

      if (enter_hs) sts_num_entered <= sts_num_entered + 1'b1;
      if (exit_hs)  sts_num_exited  <= sts_num_exited + 1'b1;
      if (enter_hs && !exit_hs)      sts_num_running <= sts_num_running + 1'b1;
      else if (!enter_hs && exit_hs) sts_num_running <= sts_num_running - 1'b1;

      // Lags the state by one edge on purpose.
      sts_busy <= in_valid || (|occ) || exit_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NLOOPS; i++) begin
        assert (!(dec[i] && !inc[i] && occ[i] == '0));
        assert (!(inc[i] && !dec[i] && occ[i] == OWIDTH'(LOOP_CAP)));
      end
    end
  end

endmodule

// File: tb/tb_accelbrot_loop_array.sv
module tb_accelbrot_loop_array;
  localparam int NL = 4, WW = 34, CW = 20, TW = 24, CAP = 2, OW = 2, LW = 2;

  logic               clk = 1'b0;
  logic               rst, ctl_drain;
  logic               sts_busy;
  logic [31:0]        sts_num_entered, sts_num_exited, sts_num_running;
  logic [NL*OW-1:0]   sts_occupancy;
  logic [WW-1:0]      enter_a, enter_b;
  logic [TW-1:0]      enter_tag;
  logic               enter_valid, enter_ready;
  logic [NL*WW-1:0]   loop_enter_a, loop_enter_b;
  logic [NL*TW-1:0]   loop_enter_tag;
  logic [NL-1:0]      loop_enter_valid, loop_enter_bp;
  logic [NL*TW-1:0]   loop_exit_tag;
  logic [NL*CW-1:0]   loop_exit_count;
  logic [NL-1:0]      loop_exit_valid, loop_exit_ready;
  logic [TW-1:0]      exit_tag;
  logic [CW-1:0]      exit_count;
  logic [LW-1:0]      exit_loop;
  logic               exit_valid, exit_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accelbrot_loop_array #(
    .NLOOPS(NL), .WWIDTH(WW), .CWIDTH(CW), .TWIDTH(TW), .LOOP_CAP(CAP)
  ) dut (
    .clk(clk), .rst(rst), .ctl_drain(ctl_drain), .sts_busy(sts_busy),
    .sts_num_entered(sts_num_entered), .sts_num_exited(sts_num_exited),
    .sts_num_running(sts_num_running), .sts_occupancy(sts_occupancy),
    .enter_a(enter_a), .enter_b(enter_b), .enter_tag(enter_tag),
    .enter_valid(enter_valid), .enter_ready(enter_ready),
    .loop_enter_a(loop_enter_a), .loop_enter_b(loop_enter_b),
    .loop_enter_tag(loop_enter_tag), .loop_enter_valid(loop_enter_valid),
    .loop_enter_bp(loop_enter_bp), .loop_exit_tag(loop_exit_tag),
    .loop_exit_count(loop_exit_count), .loop_exit_valid(loop_exit_valid),
    .loop_exit_ready(loop_exit_ready), .exit_tag(exit_tag),
    .exit_count(exit_count), .exit_loop(exit_loop), .exit_valid(exit_valid),
    .exit_ready(exit_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge (input drive point)
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] occ4(input int r0, r1, r2, r3);
    return {2'(r3), 2'(r2), 2'(r1), 2'(r0)};
  endfunction

  function automatic logic [3:0] oh(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return one << r;
  endfunction

  initial begin
    int drain_seq [6];
    drain_seq = '{0, 0, 1, 2, 2, 3};
    rst = 1'b1; ctl_drain = 1'b0;
    enter_a = '0; enter_b = '0; enter_tag = '0; enter_valid = 1'b0;
    loop_enter_bp = '0; loop_exit_valid = '0; exit_ready = 1'b0;
    for (int i = 0; i < NL; i++) begin
      loop_exit_tag[i*TW +: TW]   = TW'(100 + i);
      loop_exit_count[i*CW +: CW] = CW'(10 + i);
    end

    // reset
    nxt(); nxt();
    @(negedge clk);
    chk("rst_enter_ready", 64'(enter_ready), 0);
    chk("rst_exit_valid", 64'(exit_valid), 0);
    chk("rst_busy", 64'(sts_busy), 0);
    chk("rst_occ", 64'(sts_occupancy), 0);
    chk("rst_entered", 64'(sts_num_entered), 0);
    chk("rst_exit_ready", 64'(loop_exit_ready), 0);
    nxt();
    rst = 1'b0;

    // 8 points balanced over 4 rings
    for (int k = 0; k < 8; k++) begin
      enter_valid = 1'b1; enter_tag = TW'(k + 1);
      enter_a = WW'(k * 3); enter_b = WW'(k * 5);
      @(negedge clk);
      chk("bal_ready", 64'(enter_ready), 1);
      if (k >= 1) begin
        chk("bal_valid", 64'(loop_enter_valid), 64'(oh((k - 1) % 4)));
        chk("bal_tag", 64'(loop_enter_tag[TW-1:0]), 64'(k));
      end
      nxt();
    end
    enter_valid = 1'b0;
    @(negedge clk);
    chk("bal_valid_last", 64'(loop_enter_valid), 64'(4'b1000));
    chk("bal_tag_last", 64'(loop_enter_tag[3*TW +: TW]), 8);
    chk("bal_a_last", 64'(loop_enter_a[2*WW +: WW]), 21);
    nxt();
    @(negedge clk);
    chk("bal_occ", 64'(sts_occupancy), 64'(occ4(2, 2, 2, 2)));
    chk("bal_entered", 64'(sts_num_entered), 8);
    chk("bal_running", 64'(sts_num_running), 8);
    chk("bal_busy", 64'(sts_busy), 1);
    chk("bal_idle_valid", 64'(loop_enter_valid), 0);
    nxt();

    // capacity: 9th point is held
    enter_valid = 1'b1; enter_tag = TW'(9);
    @(negedge clk);
    chk("cap_ready9", 64'(enter_ready), 1);
    nxt();
    enter_tag = TW'(10);
    @(negedge clk);
    chk("cap_ready_hold", 64'(enter_ready), 0);
    chk("cap_no_dispatch", 64'(loop_enter_valid), 0);
    nxt();
    @(negedge clk);
    chk("cap_ready_hold2", 64'(enter_ready), 0);
    chk("cap_occ", 64'(sts_occupancy), 64'(occ4(2, 2, 2, 2)));
    chk("cap_entered", 64'(sts_num_entered), 9);
    nxt();
    enter_valid = 1'b0;

    // round-robin exits at full rate
    loop_exit_valid = 4'b1111; exit_ready = 1'b1;
    @(negedge clk);
    chk("rr_grant0", 64'(loop_exit_ready), 64'(4'b0001));
    chk("rr_exit_valid0", 64'(exit_valid), 0);
    nxt();
    @(negedge clk);
    chk("rr_grant1", 64'(loop_exit_ready), 64'(4'b0010));
    chk("rr_tag0", 64'(exit_tag), 100);
    chk("rr_loop0", 64'(exit_loop), 0);
    chk("rr_held_dispatch", 64'(loop_enter_valid), 64'(4'b0001));
    chk("rr_held_tag", 64'(loop_enter_tag[TW-1:0]), 9);
    nxt();
    for (int r = 1; r <= 3; r++) begin
      @(negedge clk);
      chk("rr_grant", 64'(loop_exit_ready), 64'(oh((r + 1) % 4)));
      chk("rr_tag", 64'(exit_tag), 64'(100 + r));
      chk("rr_count", 64'(exit_count), 64'(10 + r));
      chk("rr_loop", 64'(exit_loop), 64'(r));
      chk("rr_valid", 64'(exit_valid), 1);
      nxt();
    end

    // stall 5 cycles: output holds ring 0's result, no grants
    exit_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_grant", 64'(loop_exit_ready), 0);
      chk("stall_tag", 64'(exit_tag), 100);
      chk("stall_loop", 64'(exit_loop), 0);
      chk("stall_valid", 64'(exit_valid), 1);
      nxt();
    end
    exit_ready = 1'b1;
    @(negedge clk);
    chk("unstall_grant", 64'(loop_exit_ready), 64'(4'b0010));
    nxt();
    loop_exit_valid = '0;
    @(negedge clk);
    chk("unstall_tag", 64'(exit_tag), 101);
    chk("unstall_loop", 64'(exit_loop), 1);
    chk("unstall_grant_none", 64'(loop_exit_ready), 0);
    nxt();

    // same-cycle dispatch to and exit from ring 2
    loop_enter_bp = 4'b1011; enter_valid = 1'b1; enter_tag = TW'(20);
    @(negedge clk);
    chk("sc_ready", 64'(enter_ready), 1);
    chk("sc_exit_empty", 64'(exit_valid), 0);
    chk("sc_exited", 64'(sts_num_exited), 6);
    nxt();
    enter_tag = TW'(21); loop_exit_valid = 4'b0100;
    @(negedge clk);
    chk("sc_dispatch", 64'(loop_enter_valid), 64'(4'b0100));
    chk("sc_grant", 64'(loop_exit_ready), 64'(4'b0100));
    chk("sc_occ_before", 64'(sts_occupancy), 64'(occ4(1, 0, 1, 1)));
    chk("sc_running_before", 64'(sts_num_running), 4);
    nxt();
    enter_tag = TW'(22); loop_exit_valid = '0;
    @(negedge clk);
    chk("sc_occ_same", 64'(sts_occupancy), 64'(occ4(1, 0, 1, 1)));
    chk("sc_exit_tag", 64'(exit_tag), 102);
    chk("sc_exit_loop", 64'(exit_loop), 2);
    chk("sc_dispatch2", 64'(loop_enter_valid), 64'(4'b0100));
    chk("sc_running", 64'(sts_num_running), 5);
    nxt();
    loop_enter_bp = '0; enter_tag = TW'(23);
    @(negedge clk);
    chk("sc_running_same", 64'(sts_num_running), 5);
    chk("sc_entered", 64'(sts_num_entered), 12);
    chk("sc_min_ring", 64'(loop_enter_valid), 64'(4'b0010));
    nxt();

    // drain
    ctl_drain = 1'b1; enter_tag = TW'(24);
    @(negedge clk);
    chk("drain_ready", 64'(enter_ready), 0);
    chk("drain_held_dispatch", 64'(loop_enter_valid), 64'(4'b0001));
    chk("drain_held_tag", 64'(loop_enter_tag[TW-1:0]), 23);
    nxt();
    @(negedge clk);
    chk("drain_ready2", 64'(enter_ready), 0);
    chk("drain_no_dispatch", 64'(loop_enter_valid), 0);
    chk("drain_entered", 64'(sts_num_entered), 13);
    chk("drain_occ", 64'(sts_occupancy), 64'(occ4(2, 1, 2, 1)));
    nxt();
    enter_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      loop_exit_valid = oh(drain_seq[j]);
      @(negedge clk);
      chk("drain_grant", 64'(loop_exit_ready), 64'(oh(drain_seq[j])));
      if (j >= 1) begin
        chk("drain_exit_loop", 64'(exit_loop), 64'(drain_seq[j - 1]));
        chk("drain_exit_tag", 64'(exit_tag), 64'(100 + drain_seq[j - 1]));
      end
      nxt();
    end
    loop_exit_valid = '0;
    @(negedge clk);
    chk("drain_last_loop", 64'(exit_loop), 3);
    chk("drain_last_valid", 64'(exit_valid), 1);
    nxt();
    @(negedge clk);
    chk("drain_empty", 64'(exit_valid), 0);
    chk("drain_busy_lag", 64'(sts_busy), 1);
    nxt();
    ctl_drain = 1'b0;
    @(negedge clk);
    chk("drain_busy_off", 64'(sts_busy), 0);
    chk("drain_entered_final", 64'(sts_num_entered), 13);
    chk("drain_exited_final", 64'(sts_num_exited), 13);
    chk("drain_running_final", 64'(sts_num_running), 0);
    chk("drain_occ_final", 64'(sts_occupancy), 0);
    chk("resume_ready", 64'(enter_ready), 1);
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
